fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO; next generation of the team's synchronous DP-RAM FIFO.
- Arbitrary depth, including non-power-of-2, with a derived count width.
- Programmable almost-full and almost-empty flags.
- Sticky overflow and underflow error flags.
- Explicit read-data valid.
Sits between producer and consumer blocks in the interface subsystems (UART/SPI/I2C buffering).

---
 rtl/fifo_sync_param.sv | 142 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with arbitrary (non power-of-2) depth.
// It provides programmable almost-full and almost-empty flags, sticky
// overflow and underflow flags, and a read-data valid strobe.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through output mode.
// When the macro is not defined, the FIFO uses registered-read output mode.
//
// Handshake: a push is taken on a rising edge when wr_i is high and the
// FIFO is not full, or when it is full but a pop is taken on the same edge.
// A pop is taken when rd_i is high and the FIFO is not empty. Requests that
// are not taken are dropped. They set the matching sticky error flag.
module fifo_sync_param #(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 8,
    parameter  int AF_THRESH = 6,
    parameter  int AE_THRESH = 2,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_i,
    input  logic              clr_err_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              udf_q;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              udf_set;

    // Decide whether each request is taken this cycle, and detect error events.
    always_comb begin
        wr_acc  = wr_i & (~full_o | rd_i);
        rd_acc  = rd_i & ~empty_o;
        ovf_set = wr_i & full_o & ~rd_i;
        udf_set = rd_i & empty_o;
    end

    // Storage array. It is not reset. A write to the slot being read on the same edge is safe.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap with an explicit compare so that depths other than powers of 2 work.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    // The occupancy counter changes only when exactly one side is taken.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            count_q <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags. When a set event and a clear happen together, the set wins.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~clr_err_i);
            udf_q <= udf_set | (udf_q & ~clr_err_i);
        end
    end

    // Status flags are decoded from the registered count.
    always_comb begin
        count_o        = count_q;
        full_o         = (count_q == CNT_W'(DEPTH));
        empty_o        = (count_q == '0);
        almost_full_o  = (count_q >= CNT_W'(AF_THRESH));
        almost_empty_o = (count_q <= CNT_W'(AE_THRESH));
        overflow_o     = ovf_q;
        underflow_o    = udf_q;
    end

`ifdef FIFO_FWFT_EN
    // Fall-through output: the head word is shown whenever the FIFO holds data.
    always_comb begin
        data_o       = empty_o ? '0 : mem[rd_ptr_q];
        data_valid_o = ~empty_o;
    end
`else
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Registered read: the head word is captured on a taken pop, and the data holds otherwise.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
                data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Drive the outputs from the read registers.
    always_comb begin
        data_o       = data_q;
        data_valid_o = valid_q;
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: table of directed vectors plus random traffic for fifo_sync_param.
// The model is a queue of stored words, with flags derived from the queue size.
// Build macro FIFO_FWFT_EN must match the setting used to build the design.
module tb_fifo_sync_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 6;
    localparam int AF_TH  = 6;
    localparam int AE_TH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              srst_n;
    logic              wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic              clr;
    logic [DATA_W-1:0] dout;
    logic              dvalid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              afull;
    logic              aempty;
    logic              ovf;
    logic              udf;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DATA_W-1:0] exp_q[$];
    logic              m_ovf;
    logic              m_udf;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;

    typedef struct {
        logic              rst_n;
        logic              wr;
        logic              rd;
        logic              clr;
        logic [DATA_W-1:0] d;
        int                exp_cnt;
        logic              exp_ovf;
        logic              exp_udf;
    } vec_t;

    vec_t vecs[$];

    fifo_sync_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_TH),
        .AE_THRESH (AE_TH)
    ) dut (
        .clk_i          (clk),
        .srst_n_i       (srst_n),
        .wr_i           (wr),
        .data_i         (din),
        .rd_i           (rd),
        .clr_err_i      (clr),
        .data_o         (dout),
        .data_valid_o   (dvalid),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .overflow_o     (ovf),
        .underflow_o    (udf)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model.
    task automatic check_model();
        int sz;
        logic [DATA_W-1:0] e_data;
        logic              e_valid;
        sz = exp_q.size();
`ifdef FIFO_FWFT_EN
        e_valid = (sz > 0);
        e_data  = (sz > 0) ? exp_q[0] : '0;
`else
        e_valid = m_valid;
        e_data  = m_data;
`endif
        chk("count",        32'(count),  32'(sz));
        chk("full",         32'(full),   32'(sz == DEPTH));
        chk("empty",        32'(empty),  32'(sz == 0));
        chk("almost_full",  32'(afull),  32'(sz >= AF_TH));
        chk("almost_empty", 32'(aempty), 32'(sz <= AE_TH));
        chk("overflow",     32'(ovf),    32'(m_ovf));
        chk("underflow",    32'(udf),    32'(m_udf));
        chk("data_valid",   32'(dvalid), 32'(e_valid));
        chk("data",         32'(dout),   32'(e_data));
    endtask

    // Driver task: apply one cycle of inputs, step the model, and check the outputs.
    task automatic step(input logic rst_n, input logic w, input logic r,
                        input logic c, input logic [DATA_W-1:0] d);
        int   sz;
        logic rd_ok;
        logic wr_ok;
        logic [DATA_W-1:0] head;
        srst_n = rst_n;
        wr     = w;
        rd     = r;
        clr    = c;
        din    = d;
        sz     = exp_q.size();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_data  = '0;
            m_valid = 1'b0;
        end else begin
            rd_ok = r && (sz > 0);
            wr_ok = w && ((sz < DEPTH) || r);
            m_ovf = (w && (sz == DEPTH) && !r) || (m_ovf && !c);
            m_udf = (r && (sz == 0)) || (m_udf && !c);
            m_valid = rd_ok;
            if (rd_ok) begin
                head   = exp_q.pop_front();
                m_data = head;
            end
            if (wr_ok) exp_q.push_back(d);
        end
        check_model();
    endtask

    task automatic add(input logic rs, input logic w, input logic r, input logic c,
                       input logic [DATA_W-1:0] d, input int cnt, input logic eo, input logic eu);
        vec_t v;
        v.rst_n = rs; v.wr = w; v.rd = r; v.clr = c; v.d = d;
        v.exp_cnt = cnt; v.exp_ovf = eo; v.exp_udf = eu;
        vecs.push_back(v);
    endtask

    initial begin
        logic w;
        logic r;
        srst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;
        m_ovf = 1'b0; m_udf = 1'b0; m_data = '0; m_valid = 1'b0;

        // Directed vectors, with hand-written count and error expectations.
        add(0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h11, 1, 0, 0);
        add(1, 1, 0, 0, 8'h12, 2, 0, 0);
        add(1, 1, 0, 0, 8'h13, 3, 0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 1, 0, 0, 8'hA0 + 8'(i), i + 1, 0, 0);
        add(1, 1, 0, 0, 8'hA6, 6, 1, 0);
        add(1, 0, 0, 1, 8'h00, 6, 0, 0);
        add(1, 1, 1, 0, 8'hBB, 6, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 1, 0, 8'h00, 5 - i, 0, 0);
        add(1, 1, 1, 0, 8'hCC, 1, 0, 1);
        add(1, 0, 0, 1, 8'h00, 1, 0, 0);
        add(1, 0, 1, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].d);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_udf", i),   32'(udf),   32'(vecs[i].exp_udf));
        end

        // Wrap sequence: 10 rounds of two writes followed by two reads.
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, 0, 8'(2 * k + 1));
            step(1, 1, 0, 0, 8'(2 * k + 2));
            step(1, 0, 1, 0, 8'h00);
            step(1, 0, 1, 0, 8'h00);
        end
        chk("wrap_count_zero", 32'(count), 32'd0);

        // Fall-through style check: a single word written, then acknowledged.
        step(1, 1, 0, 0, 8'h55);
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 1, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        chk("single_word_drained", 32'(empty), 32'd1);

        // Random traffic. Phases bias the traffic toward filling, then toward draining.
        for (int i = 0; i < 600; i++) begin
            if ((i / 50) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(($urandom_range(0, 79) != 0), w, r, ($urandom_range(0, 9) == 0),
                 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
